// File: rtl/vec_mag_sq_pkg.sv
// Shared definitions for the sum-of-squares stage: state encoding, default width
// and the operand abs/clamp helper.
package vec_mag_sq_pkg;

  // Default magnitude width: 16-bit signed inputs, 31-bit unsigned result.
  localparam int unsigned MAG_W_DEF = 15;

  // State encoding.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SQ_X = 2'd1;
  localparam logic [1:0] SQ_Y = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StSqX  = SQ_X,
    StSqY  = SQ_Y
  } state_e;

  // |v| for a sign-extended (w+1)-bit value. The most negative code is the only
  // one whose magnitude reaches 2^w; pull it back to 2^w - 1 so the magnitude
  // always fits w bits.
  function automatic logic [31:0] abs_clamp(input logic signed [31:0] v,
                                            input int unsigned w);
    logic [31:0] mag;
    mag = v[31] ? 32'(-v) : 32'(v);
    if ((mag >> w) != 32'd0) begin
      mag = mag - 32'd1;
    end
    return mag;
  endfunction

endpackage

// File: rtl/vec_mag_sq_shift_add_step.sv
// One combinational shift-add squaring step: acc + (mag[idx] ? mag << idx : 0).
module vec_mag_sq_shift_add_step #(
  parameter int unsigned MAG_W = 15,
  parameter int unsigned IDX_W = 4
) (
  input  logic [2*MAG_W:0]  acc,
  input  logic [MAG_W-1:0]  mag,
  input  logic [IDX_W-1:0]  idx,
  output logic [2*MAG_W:0]  acc_next
);

  logic [2*MAG_W:0] mag_ext;
  logic [2*MAG_W:0] term;

  // Conditionally add the shifted partial product selected by the bit index.
  always_comb begin
    mag_ext  = {{(MAG_W + 1){1'b0}}, mag};
    term     = mag[idx] ? (mag_ext << idx) : '0;
    acc_next = acc + term;
  end

endmodule

// File: rtl/vec_mag_sq.sv
// Iterative x^2 + y^2 with a single time-shared shift-add squarer. Fixed latency
// of 2*MAG_W cycles from accepted start to done_stb.
module vec_mag_sq
  import vec_mag_sq_pkg::*;
#(
  parameter int unsigned MAG_W = MAG_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [MAG_W:0] x,
  input  logic signed [MAG_W:0] y,
  output logic                 busy,
  output logic                 done_stb,
  output logic [2*MAG_W:0]     sum_sq
);

  localparam int unsigned IDX_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAG_W - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [MAG_W-1:0]  mag_x_q, mag_x_d;
  logic [MAG_W-1:0]  mag_y_q, mag_y_d;
  logic [2*MAG_W:0]  acc_q, acc_d;
  logic [2*MAG_W:0]  sum_q, sum_d;
  logic              done_q, done_d;

  logic signed [31:0] x_ext, y_ext;
  logic [MAG_W-1:0]   mag_x_cap, mag_y_cap;
  logic [MAG_W-1:0]   mag_sel;
  logic [2*MAG_W:0]   step_acc;
  logic               last_step;

  // Operand conditioning: sign-extend and take clamped magnitudes.
  always_comb begin
    x_ext     = 32'(x);
    y_ext     = 32'(y);
    mag_x_cap = MAG_W'(abs_clamp(x_ext, MAG_W));
    mag_y_cap = MAG_W'(abs_clamp(y_ext, MAG_W));
    mag_sel   = (state_q == StSqY) ? mag_y_q : mag_x_q;
    last_step = (cnt_q == LAST_IDX);
  end

  vec_mag_sq_shift_add_step #(
    .MAG_W (MAG_W),
    .IDX_W (IDX_W)
  ) u_step (
    .acc      (acc_q),
    .mag      (mag_sel),
    .idx      (cnt_q),
    .acc_next (step_acc)
  );

  // Next-state logic: capture in idle, square x then accumulate y^2 on top.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_x_d = mag_x_q;
    mag_y_d = mag_y_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mag_x_d = mag_x_cap;
          mag_y_d = mag_y_cap;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StSqX;
        end
      end
      StSqX: begin
        acc_d = step_acc;
        if (last_step) begin
          cnt_d   = '0;
          state_d = StSqY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSqY: begin
        acc_d = step_acc;
        if (last_step) begin
          cnt_d   = '0;
          sum_d   = step_acc;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mag_x_q <= '0;
      mag_y_q <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_x_q <= mag_x_d;
      mag_y_q <= mag_y_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
    end
  end

  // Outputs.
  always_comb begin
    busy     = (state_q != StIdle);
    done_stb = done_q;
    sum_sq   = sum_q;
  end

endmodule

// File: tb/tb_vec_mag_sq.sv
// Directed self-checking bench for vec_mag_sq at default width (16-bit in, 31-bit out).
module tb_vec_mag_sq;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [15:0] x;
  logic signed [15:0] y;
  logic               busy;
  logic               done_stb;
  logic [30:0]        sum_sq;

  int checks = 0;
  int errors = 0;

  vec_mag_sq #(
    .MAG_W (15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x        (x),
    .y        (y),
    .busy     (busy),
    .done_stb (done_stb),
    .sum_sq   (sum_sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start one job at edge k, scramble inputs afterwards, and check the exact
  // done_stb timing and result.
  task automatic run_job(input logic signed [15:0] xv, input logic signed [15:0] yv,
                         input logic [30:0] exp, input string tag);
    int early;
    early = 0;
    x = xv;
    y = yv;
    start = 1'b1;
    tick();                      // edge k
    start = 1'b0;
    x = 16'sh1234;
    y = -16'sd77;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    for (int i = 1; i < 30; i++) begin
      tick();
      if (done_stb) early++;
    end
    chk({tag, "_early_done"}, 64'(early), 64'd0);
    tick();                      // edge k+30
    chk({tag, "_done"}, 64'(done_stb), 64'd1);
    chk({tag, "_sum"}, 64'(sum_sq), 64'(exp));
    tick();
    chk({tag, "_done_clear"}, 64'(done_stb), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_sum_hold"}, 64'(sum_sq), 64'(exp));
  endtask

  initial begin
    int ndone;
    int t_done;
    rst = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done_stb), 64'd0);
    chk("rst_sum", 64'(sum_sq), 64'd0);
    rst = 1'b0;
    tick();

    // Basic and boundary vectors.
    run_job(16'sd3, 16'sd4, 31'd25, "3_4");
    run_job(-16'sd32768, -16'sd32768, 31'd2147352578, "clamp");
    run_job(16'sd0, -16'sd1, 31'd1, "0_m1");
    run_job(-16'sd12345, 16'sd6789, 31'd198489546, "m12345_6789");
    run_job(16'sd0, 16'sd0, 31'd0, "zero");

    // Starts while busy are ignored: only the first operands count.
    x = 16'sd5;
    y = 16'sd12;
    start = 1'b1;
    tick();                      // edge k
    start = 1'b0;
    ndone = 0;
    t_done = -1;
    for (int t = 1; t <= 34; t++) begin
      if (t == 5 || t == 17) begin
        x = 16'sd1000;
        y = -16'sd1000;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (done_stb) begin
        ndone++;
        t_done = t;
      end
    end
    chk("busy_start_ndone", 64'(ndone), 64'd1);
    chk("busy_start_time", 64'(t_done), 64'd30);
    chk("busy_start_sum", 64'(sum_sq), 64'd169);

    // Reset mid-operation aborts with no done_stb.
    x = 16'sd7;
    y = 16'sd9;
    start = 1'b1;
    tick();                      // edge k
    start = 1'b0;
    for (int t = 1; t < 12; t++) tick();
    rst = 1'b1;
    tick();                      // edge k+12
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sum", 64'(sum_sq), 64'd0);
    chk("abort_done", 64'(done_stb), 64'd0);
    ndone = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (done_stb || busy) ndone++;
    end
    chk("abort_quiet", 64'(ndone), 64'd0);

    // start held high: a result every 31 cycles, operands re-captured each time.
    x = 16'sd100;
    y = 16'sd200;
    start = 1'b1;
    tick();                      // edge k
    x = 16'sd30;
    y = -16'sd40;
    ndone = 0;
    for (int t = 1; t <= 93; t++) begin
      tick();
      if (done_stb) begin
        ndone++;
        chk("cont_time", 64'(t), 64'(30 + 31 * (ndone - 1)));
        chk("cont_sum", 64'(sum_sq), (ndone == 1) ? 64'd50000 : 64'd2500);
      end
    end
    start = 1'b0;
    chk("cont_ndone", 64'(ndone), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
